// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line front end: receives 48-bit host commands, checks framing/CRC7 and replies with R1/R7.
// Build option: define SD_CMD_CRC_CHECK_EN to reject commands whose received CRC7 does not match.
module sd_cmd_responder #(
    parameter int unsigned NCR         = 2,
    parameter logic [31:0] CARD_STATUS = 32'h0000_0120
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sd_clk,
    input  logic        i_cmd_in,
    output logic        o_cmd_out,
    output logic        o_cmd_oe,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_GAP,
        S_SEND
    } state_t;

    localparam logic [6:0] NCR_CNT = 7'(NCR);

    state_t      r_state, w_state;
    logic        r_sd_clk, r_sd_clk_d, r_cmd_in;
    logic [46:0] r_shift, w_shift;
    logic [47:0] r_tx, w_tx;
    logic [6:0]  r_crc, w_crc;
    logic [6:0]  r_cnt, w_cnt;
    logic        r_cmd_out, w_cmd_out;
    logic        r_cmd_oe, w_cmd_oe;
    logic        r_valid, w_valid;
    logic        r_err, w_err;
    logic [5:0]  r_index, w_index;
    logic [31:0] r_arg, w_arg;
    logic        w_rise, w_fall, w_bad;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    assign w_rise = r_sd_clk & ~r_sd_clk_d;
    assign w_fall = ~r_sd_clk & r_sd_clk_d;

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_crc     = r_crc;
        w_cnt     = r_cnt;
        w_cmd_out = r_cmd_out;
        w_cmd_oe  = r_cmd_oe;
        w_valid   = 1'b0;
        w_err     = 1'b0;
        w_index   = r_index;
        w_arg     = r_arg;
        w_bad     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cmd_oe  = 1'b0;
                w_cmd_out = 1'b1;
                if (w_rise && !r_cmd_in) begin
                    w_shift = '0;
                    w_crc   = '0;
                    w_cnt   = 7'd46;
                    w_state = S_RECV;
                end
            end
            S_RECV: begin
                if (w_rise) begin
                    w_shift = {r_shift[45:0], r_cmd_in};
                    if (r_cnt >= 7'd8) w_crc = crc7_step(r_crc, r_cmd_in);
                    if (r_cnt == 7'd0) w_state = S_CHECK;
                    else               w_cnt   = r_cnt - 7'd1;
                end
            end
            S_CHECK: begin
                w_bad = !r_shift[46] || !r_shift[0];
`ifdef SD_CMD_CRC_CHECK_EN
                if (r_shift[7:1] != r_crc) w_bad = 1'b1;
`endif
                w_cnt = '0;
                if (w_bad) begin
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_valid = 1'b1;
                    w_index = r_shift[45:40];
                    w_arg   = r_shift[39:8];
                    if (r_shift[45:40] == 6'd0) begin
                        w_state = S_IDLE;
                    end else if (r_shift[45:40] == 6'd8) begin
                        w_tx    = {2'b00, 6'd8, 20'd0, r_shift[19:8], 8'h01};
                        w_state = S_GAP;
                    end else begin
                        w_tx    = {2'b00, r_shift[45:40], CARD_STATUS, 8'h01};
                        w_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_rise && r_cnt != NCR_CNT) begin
                    w_cnt = r_cnt + 7'd1;
                end else if (w_fall && r_cnt == NCR_CNT) begin
                    w_cmd_oe  = 1'b1;
                    w_cmd_out = r_tx[47];
                    w_crc     = '0;
                    w_cnt     = 7'd47;
                    w_state   = S_SEND;
                end
            end
            S_SEND: begin
                // r_cnt is the index of the bit currently on the line; CRC replaces bits 7:1 after bit 8 leaves.
                if (w_fall) begin
                    if (r_cnt == 7'd0) begin
                        w_cmd_oe  = 1'b0;
                        w_cmd_out = 1'b1;
                        w_state   = S_IDLE;
                    end else begin
                        if (r_cnt >= 7'd8) w_crc = crc7_step(r_crc, r_tx[47]);
                        if (r_cnt == 7'd8) w_tx = {w_crc, 1'b1, 40'd0};
                        else               w_tx = {r_tx[46:0], 1'b0};
                        w_cmd_out = w_tx[47];
                        w_cnt     = r_cnt - 7'd1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sd_clk   <= 1'b0;
            r_sd_clk_d <= 1'b0;
            r_cmd_in   <= 1'b1;
            r_shift    <= '0;
            r_tx       <= '0;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_index    <= '0;
            r_arg      <= '0;
        end else begin
            r_state    <= w_state;
            r_sd_clk   <= i_sd_clk;
            r_sd_clk_d <= r_sd_clk;
            r_cmd_in   <= i_cmd_in;
            r_shift    <= w_shift;
            r_tx       <= w_tx;
            r_crc      <= w_crc;
            r_cnt      <= w_cnt;
            r_cmd_out  <= w_cmd_out;
            r_cmd_oe   <= w_cmd_oe;
            r_valid    <= w_valid;
            r_err      <= w_err;
            r_index    <= w_index;
            r_arg      <= w_arg;
        end
    end

    assign o_cmd_out   = r_cmd_out;
    assign o_cmd_oe    = r_cmd_oe;
    assign o_cmd_valid = r_valid;
    assign o_crc_err   = r_err;
    assign o_cmd_index = r_index;
    assign o_cmd_arg   = r_arg;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: host-side frame driver, response capture and pulse monitor.
module tb_sd_cmd_responder;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sd_clk = 1'b1;
    logic        i_cmd_in = 1'b1;
    logic        o_cmd_out, o_cmd_oe, o_cmd_valid, o_crc_err;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;

    int n_tests = 0;
    int n_fail  = 0;

    sd_cmd_responder #(
        .NCR(2),
        .CARD_STATUS(32'h0000_0120)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_sd_clk(i_sd_clk),
        .i_cmd_in(i_cmd_in),
        .o_cmd_out(o_cmd_out),
        .o_cmd_oe(o_cmd_oe),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd_index(o_cmd_index),
        .o_cmd_arg(o_cmd_arg),
        .o_crc_err(o_crc_err)
    );

    always #5 clk = ~clk;

    // Pulse / hold monitor
    logic        rst_q = 1'b1;
    logic        p_valid = 1'b0, p_err = 1'b0;
    logic [5:0]  p_idx = '0;
    logic [31:0] p_arg = '0;
    int mon_valid = 0, mon_err = 0, mon_both = 0, mon_long = 0, mon_hold = 0;

    always @(posedge clk) rst_q <= i_rst;

    always @(negedge clk) begin
        if (o_cmd_valid === 1'b1) mon_valid <= mon_valid + 1;
        if (o_crc_err === 1'b1)   mon_err   <= mon_err + 1;
        if (o_cmd_valid === 1'b1 && o_crc_err === 1'b1) mon_both <= mon_both + 1;
        if ((o_cmd_valid === 1'b1 && p_valid) || (o_crc_err === 1'b1 && p_err)) mon_long <= mon_long + 1;
        if (!rst_q && o_cmd_valid !== 1'b1 && (o_cmd_index !== p_idx || o_cmd_arg !== p_arg))
            mon_hold <= mon_hold + 1;
        p_valid <= (o_cmd_valid === 1'b1);
        p_err   <= (o_crc_err === 1'b1);
        p_idx   <= o_cmd_index;
        p_arg   <= o_cmd_arg;
    end

    typedef struct {
        int          ph;
        logic [47:0] frame;
        bit          noise;
        int          exp_v;
        int          exp_e;
        logic [5:0]  idx;
        logic [31:0] arg;
        bit          resp_on;
        logic [47:0] resp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7_model(h), 1'b1};
    endfunction

    function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b00, idx, arg};
        return {h, crc7_model(h), 1'b1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One SD_CLK period starting at a negedge of clk: sample the line, then fall, then rise.
    task automatic drive_cycle(input int ph, input logic b, output logic s_oe, output logic s_out);
        s_oe     = o_cmd_oe;
        s_out    = o_cmd_out;
        i_cmd_in = b;
        i_sd_clk = 1'b0;
        repeat (ph) @(negedge clk);
        i_sd_clk = 1'b1;
        repeat (ph) @(negedge clk);
    endtask

    task automatic run_frame(input int ph, input logic [47:0] f, input bit noise, input int idle,
                             output logic [47:0] resp, output int n_oe, output int first_oe);
        logic so, sd, b;
        resp = '0;
        n_oe = 0;
        first_oe = -1;
        for (int i = 47; i >= 0; i--) drive_cycle(ph, f[i], so, sd);
        for (int k = 1; k <= idle; k++) begin
            b = (noise && k >= 2 && k < 45) ? ((k % 2) == 1) : 1'b1;
            drive_cycle(ph, b, so, sd);
            if (so === 1'b1) begin
                if (first_oe < 0) first_oe = k;
                if (n_oe < 48) resp = {resp[46:0], sd};
                n_oe++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] resp;
        int n_oe, first_oe, v0, e0, j;
        logic so, sd;

        vecs[0] = '{1, 48'h40_00000000_95, 1'b0, 1, 0, 6'd0, 32'd0, 1'b0, 48'd0};
        vecs[1] = '{2, 48'h48_000001AA_87, 1'b0, 1, 0, 6'd8, 32'h1AA, 1'b1, 48'h08_000001AA_13};
        vecs[2] = '{2, mk_cmd(6'd55, 32'd0), 1'b1, 1, 0, 6'd55, 32'd0, 1'b1, mk_resp(6'd55, 32'h120)};
`ifdef SD_CMD_CRC_CHECK_EN
        vecs[3] = '{2, 48'h48_000001AA_85, 1'b0, 0, 1, 6'd55, 32'd0, 1'b0, 48'd0};
        vecs[4] = '{2, 48'h48_000001AA_86, 1'b0, 0, 1, 6'd55, 32'd0, 1'b0, 48'd0};
        vecs[5] = '{1, 48'h00_00000000_95, 1'b0, 0, 1, 6'd55, 32'd0, 1'b0, 48'd0};
`else
        vecs[3] = '{2, 48'h48_000001AA_85, 1'b0, 1, 0, 6'd8, 32'h1AA, 1'b1, 48'h08_000001AA_13};
        vecs[4] = '{2, 48'h48_000001AA_86, 1'b0, 0, 1, 6'd8, 32'h1AA, 1'b0, 48'd0};
        vecs[5] = '{1, 48'h00_00000000_95, 1'b0, 0, 1, 6'd8, 32'h1AA, 1'b0, 48'd0};
`endif
        vecs[6] = '{2, mk_cmd(6'd17, 32'h1234_5678), 1'b1, 1, 0, 6'd17, 32'h1234_5678, 1'b1,
                    mk_resp(6'd17, 32'h120)};
        vecs[7] = '{2, mk_cmd(6'd8, 32'hABCD_E5A5), 1'b0, 1, 0, 6'd8, 32'hABCD_E5A5, 1'b1,
                    mk_resp(6'd8, 32'h0000_05A5)};

        repeat (3) @(negedge clk);
        check("reset cmd_out", 64'(o_cmd_out), 64'd1);
        check("reset cmd_oe", 64'(o_cmd_oe), 64'd0);
        check("reset valid", 64'(o_cmd_valid), 64'd0);
        check("reset crc_err", 64'(o_crc_err), 64'd0);
        check("reset index", 64'(o_cmd_index), 64'd0);
        check("reset arg", 64'(o_cmd_arg), 64'd0);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            v0 = mon_valid;
            e0 = mon_err;
            run_frame(vecs[v].ph, vecs[v].frame, vecs[v].noise, (vecs[v].ph == 1) ? 100 : 60,
                      resp, n_oe, first_oe);
            check($sformatf("v%0d valid pulses", v), 64'(mon_valid - v0), 64'(vecs[v].exp_v));
            check($sformatf("v%0d crc_err pulses", v), 64'(mon_err - e0), 64'(vecs[v].exp_e));
            check($sformatf("v%0d index", v), 64'(o_cmd_index), 64'(vecs[v].idx));
            check($sformatf("v%0d arg", v), 64'(o_cmd_arg), 64'(vecs[v].arg));
            if (vecs[v].resp_on) begin
                check($sformatf("v%0d oe periods", v), 64'(n_oe), 64'd48);
                check($sformatf("v%0d first oe period", v), 64'(first_oe), 64'd4);
                check($sformatf("v%0d response", v), 64'(resp), 64'(vecs[v].resp));
            end else begin
                check($sformatf("v%0d oe periods", v), 64'(n_oe), 64'd0);
            end
            repeat (3) @(negedge clk);
        end

        // Reset while R7 bit 20 is on the line
        for (int i = 47; i >= 0; i--) drive_cycle(2, vecs[1].frame[i], so, sd);
        j = 0;
        for (int k = 1; k <= 60 && j < 28; k++) begin
            drive_cycle(2, 1'b1, so, sd);
            if (so === 1'b1) j++;
        end
        check("mid-R7 reached bit 20", 64'(j), 64'd28);
        check("mid-R7 oe before reset", 64'(o_cmd_oe), 64'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid-R7 rst cmd_oe", 64'(o_cmd_oe), 64'd0);
        check("mid-R7 rst cmd_out", 64'(o_cmd_out), 64'd1);
        check("mid-R7 rst index", 64'(o_cmd_index), 64'd0);
        check("mid-R7 rst arg", 64'(o_cmd_arg), 64'd0);
        n_oe = 0;
        for (int k = 0; k < 30; k++) begin
            drive_cycle(2, 1'b1, so, sd);
            if (so === 1'b1) n_oe++;
        end
        check("post-reset line released", 64'(n_oe), 64'd0);

        v0 = mon_valid;
        run_frame(2, vecs[1].frame, 1'b0, 60, resp, n_oe, first_oe);
        check("post-reset CMD8 valid", 64'(mon_valid - v0), 64'd1);
        check("post-reset CMD8 index", 64'(o_cmd_index), 64'd8);
        check("post-reset CMD8 arg", 64'(o_cmd_arg), 64'h1AA);
        check("post-reset R7 oe periods", 64'(n_oe), 64'd48);
        check("post-reset R7", 64'(resp), 64'h08_000001AA_13);

        repeat (4) @(negedge clk);
        check("valid and crc_err together", 64'(mon_both), 64'd0);
        check("pulse longer than 1 clk", 64'(mon_long), 64'd0);
        check("index/arg changed outside valid", 64'(mon_hold), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
